// File: rtl/piece_board_scanner.sv
// Piece/board collision scanner: walks a 4x4 piece window against the board, optionally places it.
// Optional SCAN_EARLY_EXIT_EN: abort the scan to DONE on the first collision evaluated.
module piece_board_scanner #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic       mode,
  input  logic [4:0] piece_id,
  input  logic [5:0] pos_x,
  input  logic [5:0] pos_y,
  output logic [4:0] rom_identifier,
  output logic [2:0] rom_col,
  output logic [2:0] rom_row,
  input  logic [1:0] rom_template,
  output logic [3:0] brd_rd_x,
  output logic [4:0] brd_rd_y,
  input  logic [1:0] brd_rd_data,
  output logic       brd_we,
  output logic [3:0] brd_wr_x,
  output logic [4:0] brd_wr_y,
  output logic [1:0] brd_wr_data,
  output logic       busy,
  output logic       done,
  output logic       collide
);

  localparam int unsigned KW = 4;
  localparam int unsigned CW = 7;
  localparam int unsigned PW = 6;
  localparam int unsigned DW = 2;
  localparam logic [DW-1:0] EMPTY = 2'b11;

  typedef enum logic [2:0] {IDLE, SCAN, CHECK, WRITE, DONE} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            mode_q, mode_d;
  logic [4:0]      pid_q, pid_d;
  logic [PW-1:0]   px_q, px_d, py_q, py_d;
  logic            collide_q, collide_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pend_q, pend_d;
  logic [DW-1:0]   ev_tmpl_q, ev_tmpl_d;
  logic            ev_xbad_q, ev_xbad_d;
  logic            ev_above_q, ev_above_d;
  logic            cur_xbad_q, cur_xbad_d;
  logic            cur_above_q, cur_above_d;
  logic [2:0]      col_q, col_d, row_q, row_d;
  logic [3:0]      addr_x_q, addr_x_d;
  logic [4:0]      addr_y_q, addr_y_d;

  logic            hit;
  logic            live;
  logic            xbad;
  logic            above;
  logic [CW-1:0]   nx, ny;

  // Evaluation of the cell registered last cycle, now that its board read has returned.
  assign hit = pend_q && (ev_tmpl_q != EMPTY) &&
               (ev_xbad_q || (!ev_above_q && (brd_rd_data != EMPTY)));

  // Control: state, window index, request latch and sticky collision.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    mode_d     = mode_q;
    pid_d      = pid_q;
    px_d       = px_q;
    py_d       = py_q;
    collide_d  = collide_q;
    pend_d     = (state_q == SCAN);
    ev_tmpl_d  = ev_tmpl_q;
    ev_xbad_d  = ev_xbad_q;
    ev_above_d = ev_above_q;

    if (state_q == SCAN) begin
      ev_tmpl_d  = rom_template;
      ev_xbad_d  = cur_xbad_q;
      ev_above_d = cur_above_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = mode;
          pid_d     = piece_id;
          px_d      = pos_x;
          py_d      = pos_y;
          collide_d = 1'b0;
          k_d       = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (hit) collide_d = 1'b1;
`ifdef SCAN_EARLY_EXIT_EN
        if (hit) begin
          k_d     = '0;
          state_d = DONE;
        end else
`endif
        if (k_q == KW'(15)) begin
          k_d     = '0;
          state_d = CHECK;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      CHECK: begin
        collide_d = collide_q | hit;
        k_d       = '0;
        if (mode_q && !(collide_q || hit)) state_d = WRITE;
        else                               state_d = DONE;
      end
      WRITE: begin
        if (k_q == KW'(15)) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Window geometry for the cell presented next cycle (ROM/board addresses, bounds flags).
  always_comb begin
    live  = (state_d == SCAN) || (state_d == WRITE);
    nx    = {px_d[PW-1], px_d} + {5'b0, k_d[1:0]};
    ny    = {py_d[PW-1], py_d} + {5'b0, k_d[3:2]};
    xbad  = nx[CW-1] || (nx >= CW'(BOARD_W)) ||
            (!ny[CW-1] && (ny >= CW'(BOARD_H)));
    above = ny[CW-1];

    col_d       = live ? {1'b0, k_d[1:0]} : 3'b000;
    row_d       = live ? {1'b0, k_d[3:2]} : 3'b000;
    addr_x_d    = (live && !xbad && !above) ? nx[3:0] : 4'b0000;
    addr_y_d    = (live && !xbad && !above) ? ny[4:0] : 5'b00000;
    cur_xbad_d  = live && xbad;
    cur_above_d = live && above;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      mode_q      <= 1'b0;
      pid_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      collide_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      ev_tmpl_q   <= EMPTY;
      ev_xbad_q   <= 1'b0;
      ev_above_q  <= 1'b0;
      cur_xbad_q  <= 1'b0;
      cur_above_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      addr_x_q    <= '0;
      addr_y_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      pid_q       <= pid_d;
      px_q        <= px_d;
      py_q        <= py_d;
      collide_q   <= collide_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
      ev_tmpl_q   <= ev_tmpl_d;
      ev_xbad_q   <= ev_xbad_d;
      ev_above_q  <= ev_above_d;
      cur_xbad_q  <= cur_xbad_d;
      cur_above_q <= cur_above_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_x_q    <= addr_x_d;
      addr_y_q    <= addr_y_d;
    end
  end

  // The write strobe follows the combinational ROM so each cell lands in its own WRITE cycle.
  assign brd_we         = (state_q == WRITE) && (rom_template != EMPTY) &&
                          !cur_xbad_q && !cur_above_q;
  assign brd_wr_data    = brd_we ? rom_template : 2'b00;
  assign brd_wr_x       = addr_x_q;
  assign brd_wr_y       = addr_y_q;
  assign brd_rd_x       = addr_x_q;
  assign brd_rd_y       = addr_y_q;
  assign rom_identifier = pid_q;
  assign rom_col        = col_q;
  assign rom_row        = row_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign collide        = collide_q;

endmodule

// File: tb/tb_piece_board_scanner.sv
// Randomized bench for piece_board_scanner against a cell-list reference model.
module tb_piece_board_scanner;

  localparam int BW = 10;
  localparam int BH = 20;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       start;
  logic       mode;
  logic [4:0] piece_id;
  logic [5:0] pos_x, pos_y;
  logic [4:0] rom_identifier;
  logic [2:0] rom_col, rom_row;
  logic [1:0] rom_template;
  logic [3:0] brd_rd_x;
  logic [4:0] brd_rd_y;
  logic [1:0] brd_rd_data;
  logic       brd_we;
  logic [3:0] brd_wr_x;
  logic [4:0] brd_wr_y;
  logic [1:0] brd_wr_data;
  logic       busy, done, collide;

  logic [1:0] rom_tbl    [32][16];
  logic [1:0] board      [16][32];
  logic [1:0] board_init [16][32];
  logic       load_board;
  logic [3:0] rdx_n, wx_n;
  logic [4:0] rdy_n, wy_n;
  logic [1:0] wd_n, rd_data_q;
  logic       we_n;
  logic [10:0] exp_wr[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  piece_board_scanner #(.BOARD_W(BW), .BOARD_H(BH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .mode(mode), .piece_id(piece_id),
    .pos_x(pos_x), .pos_y(pos_y), .rom_identifier(rom_identifier), .rom_col(rom_col),
    .rom_row(rom_row), .rom_template(rom_template), .brd_rd_x(brd_rd_x),
    .brd_rd_y(brd_rd_y), .brd_rd_data(brd_rd_data), .brd_we(brd_we),
    .brd_wr_x(brd_wr_x), .brd_wr_y(brd_wr_y), .brd_wr_data(brd_wr_data),
    .busy(busy), .done(done), .collide(collide)
  );

  // Combinational piece ROM.
  always_comb rom_template = rom_tbl[rom_identifier][{rom_row[1:0], rom_col[1:0]}];

  // Board memory: DUT outputs sampled mid-cycle, applied at the next rising edge.
  always @(negedge Clk) begin
    rdx_n <= brd_rd_x;
    rdy_n <= brd_rd_y;
    we_n  <= brd_we;
    wx_n  <= brd_wr_x;
    wy_n  <= brd_wr_y;
    wd_n  <= brd_wr_data;
  end

  always @(posedge Clk) begin
    if (load_board) begin
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 32; y++)
          board[x][y] <= board_init[x][y];
    end else if (we_n) begin
      board[wx_n][wy_n] <= wd_n;
    end
    rd_data_q <= board[rdx_n][rdy_n];
  end
  assign brd_rd_data = rd_data_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int density, input int min_row);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 32; y++)
        board_init[x][y] = (x < BW && y < BH && y >= min_row &&
                            int'($urandom_range(0, 99)) < density) ?
                           2'($urandom_range(0, 2)) : 2'b11;
  endtask

  task automatic commit();
    @(negedge Clk); load_board = 1'b1;
    @(negedge Clk); load_board = 1'b0;
  endtask

  task automatic empty_board();
    fill(0, 0);
    commit();
  endtask

  // Reference: list the filled window cells and classify each against the board.
  task automatic model(input logic [4:0] pid, input int px, input int py, input logic md,
                       output logic col, output int lat);
    logic [1:0] t;
    int x, y;
    exp_wr.delete();
    col = 1'b0;
    for (int k = 0; k < 16; k++) begin
      t = rom_tbl[pid][k];
      if (t == 2'b11) continue;
      x = px + (k % 4);
      y = py + (k / 4);
      if (x < 0 || x >= BW || y >= BH) col = 1'b1;
      else if (y < 0) continue;
      else if (board[x][y] != 2'b11) col = 1'b1;
      else exp_wr.push_back({4'(x), 5'(y), t});
    end
    if (col || !md) exp_wr.delete();
    lat = (md && !col) ? 34 : 18;
  endtask

  task automatic run_op(input logic [4:0] pid, input int px, input int py, input logic md);
    logic col;
    int lat, cyc;
    logic [10:0] got[$];
    model(pid, px, py, md, col, lat);
    @(negedge Clk);
    piece_id = pid; pos_x = 6'(px); pos_y = 6'(py); mode = md; start = 1'b1;
    @(negedge Clk);
    cyc = 1;
    while (done !== 1'b1 && cyc < 80) begin
      chk("busy", 32'(busy), 1);
      chk("rom_msb", {rom_col[2], rom_row[2]}, 0);
      if (brd_we) got.push_back({brd_wr_x, brd_wr_y, brd_wr_data});
      start    = (cyc == 5);
      piece_id = 5'($urandom);
      pos_x    = 6'($urandom);
      pos_y    = 6'($urandom);
      mode     = 1'($urandom);
      @(negedge Clk);
      cyc++;
    end
    start = 1'b0;
    if (done !== 1'b1) chk("timeout", 0, 1);
    chk("latency", cyc, lat);
    chk("collide", 32'(collide), 32'(col));
    chk("busy_at_done", 32'(busy), 1);
    chk("we_at_done", 32'(brd_we), 0);
    chk("n_writes", got.size(), exp_wr.size());
    for (int i = 0; i < got.size() && i < exp_wr.size(); i++)
      chk("wr_cell", 32'(got[i]), 32'(exp_wr[i]));
    @(negedge Clk);
    chk("done_pulse", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("collide_hold", 32'(collide), 32'(col));
    chk("we_idle", 32'(brd_we), 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_collide"}, 32'(collide), 0);
    chk({tag, "_we"}, 32'(brd_we), 0);
    chk({tag, "_rdaddr"}, {brd_rd_x, brd_rd_y}, 0);
    chk({tag, "_wraddr"}, {brd_wr_x, brd_wr_y, brd_wr_data}, 0);
    chk({tag, "_rom"}, {rom_identifier, rom_col, rom_row}, 0);
  endtask

  task automatic reset_mid_write();
    int cyc;
    empty_board();
    @(negedge Clk);
    piece_id = 5'b00000; pos_x = 6'd4; pos_y = 6'd0; mode = 1'b1; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    cyc = 1;
    while (brd_we !== 1'b1 && cyc < 80) begin
      @(negedge Clk);
      cyc++;
    end
    chk("reach_write", 32'(brd_we), 1);
    #2 Reset_n = 1'b0;
    #1 reset_checks("rst_write");
    start = 1'b1;
    @(negedge Clk);
    reset_checks("rst_hold");
    start = 1'b0;
    Reset_n = 1'b1;
    empty_board();
    run_op(5'b00000, 4, 0, 1'b1);
    empty_board();
    run_op(5'b00000, 4, 0, 1'b0);
  endtask

  initial begin
    for (int id = 0; id < 32; id++)
      for (int k = 0; k < 16; k++) begin
        if (id == 0)      rom_tbl[id][k] = (k == 9 || k == 10 || k == 13 || k == 14) ? 2'b00 : 2'b11;
        else if (id == 4) rom_tbl[id][k] = (k >= 4 && k <= 7) ? 2'b01 : 2'b11;
        else              rom_tbl[id][k] = ($urandom_range(0, 3) == 0) ?
                                           2'($urandom_range(0, 2)) : 2'b11;
      end
    Reset_n = 1'b0; start = 1'b0; mode = 1'b0; piece_id = '0; pos_x = '0; pos_y = '0;
    load_board = 1'b0;
    empty_board();
    #1 reset_checks("por");
    @(negedge Clk);
    Reset_n = 1'b1;

    empty_board();
    run_op(5'b00000, 4, 0, 1'b0);
    empty_board();
    run_op(5'b00000, 4, 0, 1'b1);
    empty_board();
    run_op(5'b00100, 7, 0, 1'b1);
    fill(0, 0);
    board_init[5][3] = 2'b00;
    commit();
    run_op(5'b00000, 4, 0, 1'b1);
    empty_board();
    run_op(5'b00000, 4, -3, 1'b1);
    reset_mid_write();

    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 0) begin
        fill(25, 12);
        commit();
      end
      run_op(5'($urandom), int'($urandom_range(0, 13)) - 3,
             int'($urandom_range(0, 23)) - 4, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
